parity_mismatch_monitor: RTL and testbench

PARITY_MISMATCH_MONITOR -- requirements
Module: parity_mismatch_monitor

---
 rtl/parity_chk_pkg.sv | 19 +
 rtl/parity_sat_counter.sv | 29 ++
 rtl/parity_mismatch_monitor.sv | 140 ++++++++++++++
 tb/tb_parity_mismatch_monitor.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_chk_pkg.sv
// parity_chk_pkg
//   Shared types and default widths for the parity mismatch monitor.
//   - state_t    : monitor FSM encoding (IDLE / RUN / DONE)
//   - err_code_t : failure code, bit0 = davio_bad, bit1 = conv_bad
//   - D_W_DEFAULT / CNT_W_DEFAULT : default parameter widths
package parity_chk_pkg;

    localparam int D_W_DEFAULT   = 7;
    localparam int CNT_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef logic [1:0] err_code_t;

endpackage

// File: rtl/parity_sat_counter.sv
// parity_sat_counter
//   Up-counter that sticks at all-ones instead of wrapping.
//   Ports:
//     clk   : clock, rising edge
//     rst_n : synchronous active-low reset, clears count
//     clear : synchronous clear, has priority over en
//     en    : increment by one (ignored once count is all-ones)
//     count : current value
module parity_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/parity_mismatch_monitor.sv
// parity_mismatch_monitor
//   Compares two parity implementations (Davio and conventional) against the
//   XOR-reduction of d over a run of `limit` accepted vectors, counting
//   failures and capturing the first failing vector of the run.
//   Ports:
//     clk, rst_n           : clock and synchronous active-low reset
//     start, limit         : launch a run of `limit` vectors (from IDLE/DONE)
//     in_valid, in_ready   : vector handshake; in_ready is high only in RUN
//     d, f_davio, f_conv   : data vector and the two parity results under test
//     busy, done, pass     : run status (pass = done with no failures)
//     vec_count, err_count : accepted vectors / failing vectors (saturating)
//     err_pulse            : one cycle after each accepted failing vector
//     first_err_*          : capture of the first failing vector in the run
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | after reset, waiting for start
//   RUN   | accepting vectors until `limit` have been taken
//   DONE  | results held until the next start (or reset)
module parity_mismatch_monitor
    import parity_chk_pkg::*;
#(
    parameter int D_W   = D_W_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] limit,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [D_W-1:0]   d,
    input  logic             f_davio,
    input  logic             f_conv,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
    output logic             err_pulse,
    output logic             first_err_valid,
    output logic [D_W-1:0]   first_err_d,
    output logic [1:0]       first_err_code
);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] limit_q;
    logic [CNT_W-1:0] vec_next;
    logic             launch;
    logic             accept;
    logic             last_accept;
    logic             golden;
    logic             davio_bad;
    logic             conv_bad;
    logic             fail;
    err_code_t        code;

    assign golden    = ^d;
    assign davio_bad = f_davio ^ golden;
    assign conv_bad  = f_conv ^ golden;
    assign fail      = davio_bad | conv_bad;
    assign code      = {conv_bad, davio_bad};

    assign accept      = in_valid && (state_q == ST_RUN);
    assign vec_next    = vec_count + CNT_W'(1);
    assign last_accept = accept && (vec_next == limit_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    launch  = 1'b1;
                    // A zero-length run completes immediately without RUN.
                    state_d = (limit == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_accept) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            limit_q         <= '0;
            vec_count       <= '0;
            err_pulse       <= 1'b0;
            first_err_valid <= 1'b0;
            first_err_d     <= '0;
            first_err_code  <= '0;
        end else begin
            err_pulse <= accept && fail;
            if (launch) begin
                limit_q         <= limit;
                vec_count       <= '0;
                first_err_valid <= 1'b0;
                first_err_d     <= '0;
                first_err_code  <= '0;
            end else if (accept) begin
                vec_count <= vec_next;
                if (fail && !first_err_valid) begin
                    first_err_valid <= 1'b1;
                    first_err_d     <= d;
                    first_err_code  <= code;
                end
            end
        end
    end

    parity_sat_counter #(
        .W (CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (launch),
        .en    (accept && fail),
        .count (err_count)
    );

    // Status is a pure decode of the registered state.
    assign in_ready = (state_q == ST_RUN);
    assign busy     = (state_q == ST_RUN);
    assign done     = (state_q == ST_DONE);
    assign pass     = (state_q == ST_DONE) && (err_count == '0);

endmodule

// File: tb/tb_parity_mismatch_monitor.sv
module tb_parity_mismatch_monitor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] limit = 8'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [6:0] d = 7'd0;
    logic       f_davio = 1'b0;
    logic       f_conv = 1'b0;
    logic       busy, done, pass;
    logic [7:0] vec_count, err_count;
    logic       err_pulse;
    logic       first_err_valid;
    logic [6:0] first_err_d;
    logic [1:0] first_err_code;

    int n_asserts = 0;
    int n_fail = 0;

    // Transaction-level reference: a run is "open" while fewer than m_limit
    // vectors have been taken; expected results are plain integer tallies.
    bit         m_run = 0;
    bit         m_done = 0;
    bit         m_pulse = 0;
    bit         m_fv = 0;
    int         m_vec = 0;
    int         m_err = 0;
    int         m_limit = 0;
    logic [6:0] m_fd = '0;
    logic [1:0] m_fc = '0;
    int         pulses_seen = 0;

    parity_mismatch_monitor dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .limit           (limit),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .d               (d),
        .f_davio         (f_davio),
        .f_conv          (f_conv),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .vec_count       (vec_count),
        .err_count       (err_count),
        .err_pulse       (err_pulse),
        .first_err_valid (first_err_valid),
        .first_err_d     (first_err_d),
        .first_err_code  (first_err_code)
    );

    always #5 clk = ~clk;

    function automatic logic parity_of(input logic [6:0] v);
        return logic'($countones(v) % 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic g, db, cb;
        if (!rst_n) begin
            m_run = 0; m_done = 0; m_pulse = 0; m_fv = 0;
            m_vec = 0; m_err = 0; m_limit = 0; m_fd = '0; m_fc = '0;
        end else begin
            m_pulse = 0;
            if (m_run) begin
                if (in_valid) begin
                    g  = parity_of(d);
                    db = (f_davio != g);
                    cb = (f_conv != g);
                    m_vec++;
                    if (db || cb) begin
                        m_pulse = 1;
                        if (m_err < 255) m_err++;
                        if (!m_fv) begin
                            m_fv = 1; m_fd = d; m_fc = {cb, db};
                        end
                    end
                    if (m_vec == m_limit) begin
                        m_run = 0; m_done = 1;
                    end
                end
            end else if (start) begin
                m_limit = int'(limit);
                m_vec = 0; m_err = 0; m_fv = 0; m_fd = '0; m_fc = '0;
                m_run  = (limit != 0);
                m_done = (limit == 0);
            end
        end
    endtask

    task automatic check_all();
        chk("in_ready", in_ready, m_run);
        chk("busy", busy, m_run);
        chk("done", done, m_done);
        chk("pass", pass, m_done && (m_err == 0));
        chk("vec_count", vec_count, m_vec);
        chk("err_count", err_count, m_err);
        chk("err_pulse", err_pulse, m_pulse);
        chk("first_err_valid", first_err_valid, m_fv);
        chk("first_err_d", first_err_d, m_fd);
        chk("first_err_code", first_err_code, m_fc);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        if (err_pulse) pulses_seen++;
        check_all();
    endtask

    task automatic launch(input int lim);
        start = 1'b1;
        limit = 8'(lim);
        in_valid = 1'b0;
        tick();
        start = 1'b0;
    endtask

    // Offer one vector; fault bits flip the corresponding result vs golden.
    task automatic offer(input logic [6:0] dv, input logic bad_davio, input logic bad_conv);
        in_valid = 1'b1;
        d = dv;
        f_davio = parity_of(dv) ^ bad_davio;
        f_conv  = parity_of(dv) ^ bad_conv;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        logic [6:0] clean_d [4];
        int cyc;
        clean_d[0] = 7'h00; clean_d[1] = 7'h01; clean_d[2] = 7'h7F; clean_d[3] = 7'h55;

        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        chk("reset_done", done, 1'b0);
        chk("reset_ready", in_ready, 1'b0);
        rst_n = 1'b1;
        tick();

        // Clean run
        pulses_seen = 0;
        launch(4);
        for (int i = 0; i < 4; i++) offer(clean_d[i], 1'b0, 1'b0);
        tick();
        chk("clean_done", done, 1'b1);
        chk("clean_pass", pass, 1'b1);
        chk("clean_vec", vec_count, 8'd4);
        chk("clean_err", err_count, 8'd0);
        chk("clean_no_pulse", pulses_seen, 0);

        // Single Davio fault on the second vector
        launch(3);
        offer(7'h05, 1'b0, 1'b0);
        offer(7'h03, 1'b1, 1'b0);
        chk("davio_pulse_next_cycle", err_pulse, 1'b1);
        offer(7'h11, 1'b0, 1'b0);
        chk("davio_pulse_single", err_pulse, 1'b0);
        tick();
        chk("davio_err", err_count, 8'd1);
        chk("davio_first_d", first_err_d, 7'h03);
        chk("davio_first_code", first_err_code, 2'b01);
        chk("davio_pass", pass, 1'b0);

        // First capture holds across later failures
        launch(2);
        offer(7'h10, 1'b0, 1'b1);
        offer(7'h20, 1'b1, 1'b1);
        tick();
        chk("hold_first_d", first_err_d, 7'h10);
        chk("hold_first_code", first_err_code, 2'b10);
        chk("hold_err", err_count, 8'd2);

        // limit = 0 goes straight to DONE
        pulses_seen = 0;
        launch(0);
        chk("lim0_done", done, 1'b1);
        chk("lim0_ready", in_ready, 1'b0);
        chk("lim0_pass", pass, 1'b1);
        tick();
        chk("lim0_ready_hold", in_ready, 1'b0);

        // 300 failing vectors offered with limit = 255
        launch(255);
        for (int i = 0; i < 300; i++) begin
            in_valid = 1'b1;
            d = 7'($urandom);
            f_davio = ~parity_of(d);
            f_conv  = parity_of(d);
            tick();
        end
        in_valid = 1'b0;
        chk("sat_err", err_count, 8'd255);
        chk("sat_vec", vec_count, 8'd255);
        chk("sat_ready_low", in_ready, 1'b0);

        // Randomized runs against the reference model
        for (int r = 0; r < 12; r++) begin
            launch($urandom_range(1, 16));
            cyc = 0;
            while (!m_done && cyc < 200) begin
                in_valid = 1'($urandom_range(0, 3) != 0);
                d = 7'($urandom);
                f_davio = parity_of(d) ^ 1'($urandom_range(0, 3) == 0);
                f_conv  = parity_of(d) ^ 1'($urandom_range(0, 3) == 0);
                start = 1'($urandom_range(0, 5) == 0);
                limit = 8'($urandom);
                tick();
                cyc++;
            end
            start = 1'b0;
            in_valid = 1'b0;
            chk("rand_run_finished", done, 1'b1);
            tick();
        end

        // Reset mid-run, colliding with start and a valid vector
        launch(5);
        offer(7'h01, 1'b1, 1'b0);
        offer(7'h02, 1'b0, 1'b0);
        rst_n = 1'b0;
        start = 1'b1;
        limit = 8'd9;
        in_valid = 1'b1;
        tick();
        rst_n = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        chk("rst_vec", vec_count, 8'd0);
        chk("rst_err", err_count, 8'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_first_valid", first_err_valid, 1'b0);
        tick();
        launch(3);
        offer(7'h0F, 1'b0, 1'b0);
        chk("restart_vec", vec_count, 8'd1);
        offer(7'h0E, 1'b0, 1'b0);
        offer(7'h0D, 1'b0, 1'b0);

        // Back-pressure with start pulsed during RUN
        launch(10);
        cyc = 0;
        while (!m_done && cyc < 100) begin
            in_valid = cyc[0];
            d = 7'($urandom);
            f_davio = parity_of(d);
            f_conv  = parity_of(d);
            start = (cyc == 3) || (cyc == 8);
            limit = 8'd2;
            tick();
            cyc++;
        end
        start = 1'b0;
        in_valid = 1'b1;
        chk("bp_finished", done, 1'b1);
        chk("bp_vec", vec_count, 8'd10);
        chk("bp_ready_low", in_ready, 1'b0);
        tick();
        chk("bp_no_extra", vec_count, 8'd10);
        in_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
